prbs_frame_gen: RTL

PRBS_FRAME_GEN -- requirements
Module: prbs_frame_gen

---
 rtl/prbs_frame_gen_pkg.sv | 23 ++
 rtl/prbs_frame_gen_par_step.sv | 29 ++
 rtl/prbs_frame_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/prbs_frame_gen_pkg.sv
// Shared definitions for the PRBS31 frame generator: FSM encoding, LFSR taps
// and the value substituted for an all-zero seed.
package prbs_frame_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam int LFSR_W = 31;
   localparam int TAP_HI = 30;
   localparam int TAP_LO = 27;

   localparam logic [LFSR_W-1:0] LFSR_INIT      = 31'h7FFF_FFFF;
   localparam logic [LFSR_W-1:0] ZERO_SEED_SUB  = 31'h7FFF_FFFF;

   // An all-zero state would lock the LFSR, so it is swapped for all-ones.
   function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] seed);
      return (seed == '0) ? ZERO_SEED_SUB : seed;
   endfunction

endpackage

// File: rtl/prbs_frame_gen_par_step.sv
// Advances the PRBS31 LFSR by C_DATA_WIDTH bit-steps in one cycle and
// collects the generated bits, first-generated bit in the MSB.
module prbs_par_step
   import prbs_frame_gen_pkg::*;
#(
   parameter int C_DATA_WIDTH = 32
)
(
   input  logic [LFSR_W-1:0]       state,
   output logic [LFSR_W-1:0]       state_next,
   output logic [C_DATA_WIDTH-1:0] data
);

   logic [LFSR_W-1:0] s;
   logic              nb;

   always_comb begin
      s    = state;
      nb   = 1'b0;
      data = '0;
      for (int i = 0; i < C_DATA_WIDTH; i++) begin
         nb                         = s[TAP_HI] ^ s[TAP_LO];
         data[C_DATA_WIDTH-1-i]     = nb;
         s                          = {s[LFSR_W-2:0], nb};
      end
      state_next = s;
   end

endmodule

// File: rtl/prbs_frame_gen.sv
// PRBS31 framed AXI-Stream source with programmable frame and gap lengths.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no frame in progress; waits for i_enable
//   SEND    | emitting beats of the current frame until tlast handshakes
//   GAP     | idle cycles between frames, counted down from i_gap_len
module prbs_frame_gen
   import prbs_frame_gen_pkg::*;
#(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_LEN_WIDTH  = 16,
   parameter int C_CNT_WIDTH  = 32
)
(
   input  logic                    i_aclk,
   input  logic                    i_aresetn,
   input  logic                    i_enable,
   input  logic                    i_reload,
   input  logic [LFSR_W-1:0]       i_seed,
   input  logic [C_LEN_WIDTH-1:0]  i_frame_len,
   input  logic [C_LEN_WIDTH-1:0]  i_gap_len,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tvalid,
   output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                    m_axis_sof,
   output logic                    m_axis_tlast,
   output logic                    o_busy,
   output logic [C_CNT_WIDTH-1:0]  o_frame_cnt
);

   localparam logic [C_LEN_WIDTH-1:0] LEN_ONE = {{(C_LEN_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                   state;
   state_t                   state_nxt;
   logic [LFSR_W-1:0]        lfsr;
   logic [LFSR_W-1:0]        step_src;
   logic [LFSR_W-1:0]        step_next;
   logic [C_DATA_WIDTH-1:0]  step_data;
   logic [C_LEN_WIDTH-1:0]   beats_rem;
   logic [C_LEN_WIDTH-1:0]   gap_cnt;
   logic [C_LEN_WIDTH-1:0]   len_eff;
   logic                     first_beat;
   logic                     last_hs;
   logic                     gap_done;
   logic                     idle_start;
   logic                     chain_start;
   logic                     to_gap;
   logic                     beat_load;
   logic                     reload_ok;

   assign len_eff     = (i_frame_len == '0) ? LEN_ONE : i_frame_len;
   assign last_hs     = (state == ST_SEND) && m_axis_tvalid && m_axis_tready && m_axis_tlast;
   assign gap_done    = (state == ST_GAP) && (gap_cnt == LEN_ONE);
   assign idle_start  = (state == ST_IDLE) && i_enable;
   assign to_gap      = last_hs && (i_gap_len != '0);
   // A follow-on frame loads its first beat in the same cycle it starts, so
   // the bus sees exactly i_gap_len idle cycles (none when back-to-back).
   assign chain_start = i_enable && ((last_hs && (i_gap_len == '0)) || gap_done);
   assign beat_load   = chain_start ||
                        ((state == ST_SEND) && (beats_rem != '0) &&
                         (!m_axis_tvalid || m_axis_tready));
   assign reload_ok   = i_reload && ((state == ST_IDLE) || (state == ST_GAP));
   assign step_src    = reload_ok ? seed_fix(i_seed) : lfsr;
   assign o_busy      = (state != ST_IDLE);

   prbs_par_step #(
      .C_DATA_WIDTH (C_DATA_WIDTH)
   ) u_step (
      .state      (step_src),
      .state_next (step_next),
      .data       (step_data)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (i_enable) state_nxt = ST_SEND;
         ST_SEND: begin
            if (last_hs) begin
               if (i_gap_len != '0) state_nxt = ST_GAP;
               else if (i_enable)   state_nxt = ST_SEND;
               else                 state_nxt = ST_IDLE;
            end
         end
         ST_GAP:  if (gap_done) state_nxt = i_enable ? ST_SEND : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         lfsr          <= LFSR_INIT;
         beats_rem     <= '0;
         gap_cnt       <= '0;
         first_beat    <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_sof    <= 1'b0;
         m_axis_tlast  <= 1'b0;
         o_frame_cnt   <= '0;
      end else begin
         if (beat_load)      lfsr <= step_next;
         else if (reload_ok) lfsr <= step_src;

         if (chain_start) begin
            beats_rem  <= len_eff - LEN_ONE;
            first_beat <= 1'b0;
         end else if (idle_start) begin
            beats_rem  <= len_eff;
            first_beat <= 1'b1;
         end else if (beat_load) begin
            beats_rem  <= beats_rem - LEN_ONE;
            first_beat <= 1'b0;
         end

         if (to_gap)
            gap_cnt <= i_gap_len;
         else if ((state == ST_GAP) && (gap_cnt != '0))
            gap_cnt <= gap_cnt - LEN_ONE;

         // The output register holds while stalled, keeping the beat stable.
         if (beat_load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= step_data;
            m_axis_sof    <= chain_start | first_beat;
            m_axis_tlast  <= chain_start ? (len_eff == LEN_ONE) : (beats_rem == LEN_ONE);
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end

         if (last_hs) o_frame_cnt <= o_frame_cnt + CNT_ONE;
      end
   end

endmodule
